// File: rtl/ssio_sdr_tx_framer.sv
// Byte-stream framer/serializer feeding the SDR output stage: preamble, SFD, payload,
// optional CRC-8 (enabled by defining SSIO_SDR_TX_CRC_EN), then the inter-frame gap.
module ssio_sdr_tx_framer #(
  parameter int         OUT_WIDTH    = 4,
  parameter int         PREAMBLE_LEN = 7,
  parameter int         IFG_LEN      = 12,
  parameter logic [7:0] IDLE_BYTE    = 8'h07
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic [OUT_WIDTH-1:0] output_d,
  output logic                 busy,
  output logic                 frame_sent,
  output logic                 underflow
);

  localparam int         BEATS      = 8 / OUT_WIDTH;
  localparam logic [2:0] LAST_BEAT  = 3'(BEATS - 1);
  localparam logic [3:0] PRE_LEN    = 4'(PREAMBLE_LEN);
  localparam logic [5:0] GAP_LAST   = 6'(IFG_LEN - 1);
  localparam logic [7:0] PRE_BYTE   = 8'h55;
  localparam logic [7:0] SFD_BYTE   = 8'hD5;
  localparam logic [7:0] ABORT_BYTE = 8'hFE;

`ifdef SSIO_SDR_TX_CRC_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, PREAMBLE = 3'd1, PAYLOAD = 3'd2, DISCARD = 3'd3, IFG = 3'd4, CRC = 3'd5
  } state_t;

  // CRC-8, polynomial 0x07, MSB-first, no reflection
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  logic [7:0] crc_r;
  logic [7:0] crc_nx_s;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, PREAMBLE = 3'd1, PAYLOAD = 3'd2, DISCARD = 3'd3, IFG = 3'd4
  } state_t;
`endif

  state_t     state_r, state_nx_s;
  logic [2:0] beat_r;
  logic [7:0] shreg_r;
  logic [7:0] shift_s;
  logic [7:0] load_byte_s;
  logic [3:0] pcnt_r, pcnt_nx_s;
  logic [5:0] gcnt_r, gcnt_nx_s;
  logic       last_seen_r, last_seen_nx_s;
  logic       boundary_s;
  logic       frame_sent_s;
  logic       underflow_s;

  assign boundary_s    = (beat_r == LAST_BEAT);
  assign shift_s       = shreg_r >> OUT_WIDTH;
  assign s_axis_tready = ((state_r == PAYLOAD) && boundary_s) || (state_r == DISCARD);

  // Next-state and byte-selection logic; only DISCARD reacts between slot boundaries
  always_comb begin
    state_nx_s     = state_r;
    pcnt_nx_s      = pcnt_r;
    gcnt_nx_s      = gcnt_r;
    load_byte_s    = IDLE_BYTE;
    frame_sent_s   = 1'b0;
    underflow_s    = 1'b0;
`ifdef SSIO_SDR_TX_CRC_EN
    crc_nx_s       = crc_r;
`endif
    if ((state_r == DISCARD) && s_axis_tvalid && s_axis_tlast) begin
      last_seen_nx_s = 1'b1;
    end else begin
      last_seen_nx_s = last_seen_r;
    end

    if (boundary_s) begin
      case (state_r)
        IDLE: begin
          if (s_axis_tvalid) begin
            load_byte_s = PRE_BYTE;
            pcnt_nx_s   = 4'd1;
            state_nx_s  = PREAMBLE;
`ifdef SSIO_SDR_TX_CRC_EN
            crc_nx_s    = 8'h00;
`endif
          end else begin
            load_byte_s = IDLE_BYTE;
          end
        end
        PREAMBLE: begin
          if (pcnt_r < PRE_LEN) begin
            load_byte_s = PRE_BYTE;
            pcnt_nx_s   = pcnt_r + 4'd1;
          end else begin
            load_byte_s = SFD_BYTE;
            state_nx_s  = PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (s_axis_tvalid) begin
            load_byte_s = s_axis_tdata;
`ifdef SSIO_SDR_TX_CRC_EN
            crc_nx_s    = crc8_update(crc_r, s_axis_tdata);
`endif
            if (s_axis_tlast) begin
`ifdef SSIO_SDR_TX_CRC_EN
              state_nx_s   = CRC;
`else
              state_nx_s   = IFG;
              gcnt_nx_s    = 6'd0;
              frame_sent_s = 1'b1;
`endif
            end else begin
              state_nx_s = PAYLOAD;
            end
          end else begin
            // Payload gap: mark the frame bad on the line and drain the rest of the packet
            load_byte_s    = ABORT_BYTE;
            underflow_s    = 1'b1;
            last_seen_nx_s = 1'b0;
            state_nx_s     = DISCARD;
          end
        end
`ifdef SSIO_SDR_TX_CRC_EN
        CRC: begin
          load_byte_s  = crc_r;
          frame_sent_s = 1'b1;
          gcnt_nx_s    = 6'd0;
          state_nx_s   = IFG;
        end
`endif
        DISCARD: begin
          load_byte_s = IDLE_BYTE;
          if (last_seen_r || (s_axis_tvalid && s_axis_tlast)) begin
            last_seen_nx_s = 1'b0;
            gcnt_nx_s      = 6'd0;
            state_nx_s     = IFG;
          end else begin
            state_nx_s = DISCARD;
          end
        end
        IFG: begin
          load_byte_s = IDLE_BYTE;
          if (gcnt_r == GAP_LAST) begin
            gcnt_nx_s  = 6'd0;
            state_nx_s = IDLE;
          end else begin
            gcnt_nx_s  = gcnt_r + 6'd1;
          end
        end
        default: begin
          load_byte_s = IDLE_BYTE;
          state_nx_s  = IDLE;
        end
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // State, counters, shift register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      beat_r      <= 3'd0;
      shreg_r     <= IDLE_BYTE;
      output_d    <= IDLE_BYTE[OUT_WIDTH-1:0];
      pcnt_r      <= 4'd0;
      gcnt_r      <= 6'd0;
      last_seen_r <= 1'b0;
      busy        <= 1'b0;
      frame_sent  <= 1'b0;
      underflow   <= 1'b0;
`ifdef SSIO_SDR_TX_CRC_EN
      crc_r       <= 8'h00;
`endif
    end else begin
      state_r     <= state_nx_s;
      beat_r      <= boundary_s ? 3'd0 : (beat_r + 3'd1);
      pcnt_r      <= pcnt_nx_s;
      gcnt_r      <= gcnt_nx_s;
      last_seen_r <= last_seen_nx_s;
      busy        <= (state_nx_s != IDLE);
      frame_sent  <= frame_sent_s;
      underflow   <= underflow_s;
`ifdef SSIO_SDR_TX_CRC_EN
      crc_r       <= crc_nx_s;
`endif
      if (boundary_s) begin
        shreg_r  <= load_byte_s;
        output_d <= load_byte_s[OUT_WIDTH-1:0];
      end else begin
        shreg_r  <= shift_s;
        output_d <= shift_s[OUT_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_ssio_sdr_tx_framer.sv
// Directed bench for ssio_sdr_tx_framer: three instances (OUT_WIDTH 4, 1, 8) share clk/rst;
// the word stream of the selected instance is reassembled LSB-first into bytes and compared.
module tb_ssio_sdr_tx_framer;

`ifdef SSIO_SDR_TX_CRC_EN
  localparam int CRC_ON = 1;
`else
  localparam int CRC_ON = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tdata = 8'h00;
  logic       tvalid = 1'b0;
  logic       tlast = 1'b0;
  int         sel = 0;
  int         beats = 2;

  logic [3:0] od4;
  logic [0:0] od1;
  logic [7:0] od8;
  logic       rdy4, rdy1, rdy8, busy4, busy1, busy8, fs4, fs1, fs8, uf4, uf1, uf8;

  always #5 clk = ~clk;

  ssio_sdr_tx_framer #(.OUT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid && (sel == 0)),
    .s_axis_tready(rdy4), .s_axis_tlast(tlast), .output_d(od4), .busy(busy4),
    .frame_sent(fs4), .underflow(uf4));
  ssio_sdr_tx_framer #(.OUT_WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid && (sel == 1)),
    .s_axis_tready(rdy1), .s_axis_tlast(tlast), .output_d(od1), .busy(busy1),
    .frame_sent(fs1), .underflow(uf1));
  ssio_sdr_tx_framer #(.OUT_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid && (sel == 2)),
    .s_axis_tready(rdy8), .s_axis_tlast(tlast), .output_d(od8), .busy(busy8),
    .frame_sent(fs8), .underflow(uf8));

  logic [7:0] cur_word;
  logic       cur_ready, cur_busy, cur_fs, cur_uf;
  assign cur_word  = (sel == 0) ? {4'b0000, od4} : (sel == 1) ? {7'b0000000, od1} : od8;
  assign cur_ready = (sel == 0) ? rdy4 : (sel == 1) ? rdy1 : rdy8;
  assign cur_busy  = (sel == 0) ? busy4 : (sel == 1) ? busy1 : busy8;
  assign cur_fs    = (sel == 0) ? fs4 : (sel == 1) ? fs1 : fs8;
  assign cur_uf    = (sel == 0) ? uf4 : (sel == 1) ? uf1 : uf8;

  logic [8:0] src_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] obs_b[$];
  bit         obs_busy[$];
  bit         obs_fs[$];
  bit         obs_uf[$];
  int         wcnt, fs_cnt, uf_cnt, rdy_cnt;
  logic [7:0] acc;
  bit         busy_first, fs_acc, uf_acc;
  int         total = 0;
  int         bad = 0;

  task automatic drive();
    if (src_q.size() > 0) begin
      tvalid = 1'b1;
      tdata  = src_q[0][7:0];
      tlast  = src_q[0][8];
    end else begin
      tvalid = 1'b0;
      tdata  = 8'h00;
      tlast  = 1'b0;
    end
  endtask

  task automatic clear_obs();
    wcnt = 0; fs_cnt = 0; uf_cnt = 0; rdy_cnt = 0;
    obs_b.delete(); obs_busy.delete(); obs_fs.delete(); obs_uf.delete();
  endtask

  // One clock: sample outputs (#1 after the edge), record handshake, advance
  task automatic cycle();
    logic hs;
    if (wcnt == 0) begin
      acc = 8'h00; busy_first = cur_busy; fs_acc = 1'b0; uf_acc = 1'b0;
    end
    acc = acc | (cur_word << (wcnt * (8 / beats)));
    fs_acc = fs_acc | cur_fs;
    uf_acc = uf_acc | cur_uf;
    if (cur_fs) fs_cnt++;
    if (cur_uf) uf_cnt++;
    if (cur_ready) rdy_cnt++;
    hs = tvalid && cur_ready;
    if (wcnt == beats - 1) begin
      obs_b.push_back(acc); obs_busy.push_back(busy_first);
      obs_fs.push_back(fs_acc); obs_uf.push_back(uf_acc);
      wcnt = 0;
    end else begin
      wcnt++;
    end
    @(posedge clk); #1;
    if (hs) void'(src_q.pop_front());
    drive();
  endtask

  task automatic run_bytes(input int n);
    repeat (n * beats) cycle();
  endtask

  task automatic do_reset(input int s);
    sel = s;
    beats = (s == 0) ? 2 : (s == 1) ? 8 : 1;
    src_q.delete();
    drive();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_obs();
  endtask

  task automatic build_frame_exp(input logic [7:0] crc);
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
  endtask

  task automatic test_reset();
    do_reset(0);
    total++; if (cur_word !== 8'h07) begin bad++; $display("FAIL reset_output_d: got %h want 07", cur_word); end
    total++; if (cur_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", cur_busy); end
    total++; if (cur_ready !== 1'b0) begin bad++; $display("FAIL reset_tready: got %b want 0", cur_ready); end
    total++; if ((cur_fs | cur_uf) !== 1'b0) begin bad++; $display("FAIL reset_pulses: fs=%b uf=%b want 0", cur_fs, cur_uf); end
    run_bytes(4);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs_b[i] !== 8'h07 || obs_busy[i] !== 1'b0) begin
        bad++; $display("FAIL idle_byte[%0d]: got %h busy=%b want 07 busy=0", i, obs_b[i], obs_busy[i]);
      end
    end
    total++; if (rdy_cnt != 0) begin bad++; $display("FAIL idle_tready: got %0d cycles high want 0", rdy_cnt); end
  endtask

  task automatic test_frame(input int s);
    int g1;
    do_reset(s);
    src_q = '{9'h001, 9'h002, 9'h103};
    drive();
    exp_q.delete();
    exp_q.push_back(8'h07);
    build_frame_exp(8'h00);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
    if (CRC_ON == 1) exp_q.push_back(8'h48);
    repeat (12) exp_q.push_back(8'h07);
    run_bytes(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_b[i] !== exp_q[i]) begin
        bad++; $display("FAIL frame_sel%0d byte[%0d]: got %h want %h", s, i, obs_b[i], exp_q[i]);
      end
    end
    g1 = 12 + CRC_ON;
    total++; if (obs_busy[1] !== 1'b1) begin bad++; $display("FAIL frame_sel%0d busy_pre: got %b want 1", s, obs_busy[1]); end
    total++; if (obs_busy[g1 + 10] !== 1'b1) begin bad++; $display("FAIL frame_sel%0d busy_gap11: got %b want 1", s, obs_busy[g1 + 10]); end
    total++; if (obs_busy[g1 + 11] !== 1'b0) begin bad++; $display("FAIL frame_sel%0d busy_gap12: got %b want 0", s, obs_busy[g1 + 11]); end
    total++; if (obs_fs[11 + CRC_ON] !== 1'b1) begin bad++; $display("FAIL frame_sel%0d fs_pos: got %b want 1", s, obs_fs[11 + CRC_ON]); end
    total++; if (fs_cnt != 1 || uf_cnt != 0) begin bad++; $display("FAIL frame_sel%0d pulses: fs=%0d uf=%0d want 1/0", s, fs_cnt, uf_cnt); end
    total++; if (src_q.size() != 0) begin bad++; $display("FAIL frame_sel%0d consumed: left %0d want 0", s, src_q.size()); end
  endtask

  task automatic test_underflow();
    do_reset(0);
    src_q = '{9'h001, 9'h002};
    drive();
    exp_q.delete();
    exp_q.push_back(8'h07);
    build_frame_exp(8'h00);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'hFE);
    repeat (3) exp_q.push_back(8'h07);
    run_bytes(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_b[i] !== exp_q[i]) begin
        bad++; $display("FAIL underflow byte[%0d]: got %h want %h", i, obs_b[i], exp_q[i]);
      end
    end
    total++; if (obs_uf[11] !== 1'b1) begin bad++; $display("FAIL underflow_pos: got %b want 1", obs_uf[11]); end
    total++; if (obs_busy[14] !== 1'b1) begin bad++; $display("FAIL discard_busy: got %b want 1", obs_busy[14]); end
    src_q = '{9'h003, 9'h104};
    drive();
    run_bytes(16);
    for (int i = 15; i < 31; i++) begin
      total++;
      if (obs_b[i] !== 8'h07) begin bad++; $display("FAIL discard byte[%0d]: got %h want 07", i, obs_b[i]); end
    end
    total++; if (src_q.size() != 0) begin bad++; $display("FAIL discard_consumed: left %0d want 0", src_q.size()); end
    total++; if (uf_cnt != 1 || fs_cnt != 0) begin bad++; $display("FAIL underflow_pulses: uf=%0d fs=%0d want 1/0", uf_cnt, fs_cnt); end
    total++; if (obs_busy[30] !== 1'b0) begin bad++; $display("FAIL underflow_idle_busy: got %b want 0", obs_busy[30]); end
  endtask

  task automatic test_back_to_back();
    do_reset(0);
    src_q = '{9'h001, 9'h002, 9'h103, 9'h00A, 9'h10B};
    drive();
    exp_q.delete();
    exp_q.push_back(8'h07);
    build_frame_exp(8'h00);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
    if (CRC_ON == 1) exp_q.push_back(8'h48);
    repeat (12) exp_q.push_back(8'h07);
    build_frame_exp(8'h00);
    exp_q.push_back(8'h0A); exp_q.push_back(8'h0B);
    if (CRC_ON == 1) exp_q.push_back(8'hB3);
    repeat (12) exp_q.push_back(8'h07);
    run_bytes(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_b[i] !== exp_q[i]) begin
        bad++; $display("FAIL b2b byte[%0d]: got %h want %h", i, obs_b[i], exp_q[i]);
      end
    end
    total++; if (fs_cnt != 2 || uf_cnt != 0) begin bad++; $display("FAIL b2b_pulses: fs=%0d uf=%0d want 2/0", fs_cnt, uf_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset(0);
    src_q = '{9'h001, 9'h002, 9'h103};
    drive();
    run_bytes(10);
    cycle();
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (cur_word !== 8'h07) begin bad++; $display("FAIL midrst_output_d: got %h want 07", cur_word); end
    total++; if (cur_busy !== 1'b0 || cur_ready !== 1'b0) begin bad++; $display("FAIL midrst_busy_tready: got %b/%b want 0/0", cur_busy, cur_ready); end
    rst = 1'b0;
    src_q.delete();
    drive();
    clear_obs();
    run_bytes(3);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs_b[i] !== 8'h07 || obs_busy[i] !== 1'b0) begin
        bad++; $display("FAIL midrst byte[%0d]: got %h busy=%b want 07 busy=0", i, obs_b[i], obs_busy[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame(0);
    test_frame(1);
    test_frame(2);
    test_underflow();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ssio_sdr_tx_framer.md
Name: ssio_sdr_tx_framer

Overview:
Byte-stream framer and serializer that produces the `input_d` word stream for the source-synchronous SDR differential output stage.
- Accepts AXI-stream bytes and wraps each packet as: preamble, SFD, payload, optional CRC-8, inter-frame gap.
- Emits each byte LSB-first as 8/OUT_WIDTH consecutive OUT_WIDTH-bit words, one word per `clk`.
- Line-side status pulses (frame sent, underflow) go to the MAC-level control logic.

Parameters:
- OUT_WIDTH, 4, output word width; legal values 1, 2, 4, 8; matches WIDTH of the output stage.
- PREAMBLE_LEN, 7, number of 0x55 bytes before the SFD; range 1..15.
- IFG_LEN, 12, number of IDLE_BYTE bytes after every frame; range 1..63.
- IDLE_BYTE, 8'h07, byte sent when idle and during the gap.

Ports:
- clk  input  1  single clock; also clocks the downstream output stage.
- rst  input  1  synchronous, active-high reset.
- s_axis_tdata  input  8  payload byte.
- s_axis_tvalid  input  1  byte valid.
- s_axis_tready  output  1  byte accepted when tvalid & tready.
- s_axis_tlast  input  1  last payload byte of the packet.
- output_d  output  OUT_WIDTH  serialized word; connects to the output stage's `input_d`.
- busy  output  1  high in every state except IDLE.
- frame_sent  output  1  1-cycle pulse, frame completed normally.
- underflow  output  1  1-cycle pulse, frame aborted because of a payload gap.

Behaviour:
- Clock and reset: one clock (`clk`); reset (`rst`) is synchronous and active-high.
- Reset values: state=IDLE, beat=0, shift register=IDLE_BYTE, output_d=IDLE_BYTE[OUT_WIDTH-1:0], busy=0, frame_sent=0, underflow=0, s_axis_tready=0.
- Beat timing:
  - BEATS=8/OUT_WIDTH. The beat counter runs 0..BEATS-1 continuously.
  - A slot boundary is the cycle where beat==BEATS-1.
  - Exactly one new byte is loaded per slot boundary.
  - output_d is registered and equals shreg[OUT_WIDTH-1:0].
  - On non-boundary cycles the shift register shifts right by OUT_WIDTH.
- Latency: a byte chosen at boundary cycle t appears as its low word on output_d at t+1, upper words on following cycles.
- s_axis_tready is combinational: (state==PAYLOAD && beat==BEATS-1) || state==DISCARD. It is never high in any other state.
- State decisions are made only at slot boundaries, except in DISCARD, which acts every cycle.
- IDLE:
  - Load IDLE_BYTE.
  - If s_axis_tvalid, load 0x55 instead, set pcnt=1 and go to PREAMBLE. The byte is not consumed.
- PREAMBLE:
  - If pcnt<PREAMBLE_LEN, load 0x55 and increment pcnt.
  - Otherwise load 0xD5 (SFD) and go to PAYLOAD.
- PAYLOAD:
  - tvalid=1: load tdata and update CRC. If tlast, go to CRC when the feature is enabled, else go to IFG with frame_sent pulsed.
  - tvalid=0: load 0xFE (abort byte), pulse underflow, go to DISCARD.
- DISCARD:
  - tready=1 every cycle; incoming bytes are dropped.
  - Output continues to serialize; IDLE_BYTE is loaded at each boundary.
  - On tvalid&tlast, go to IFG at the next boundary. frame_sent is not pulsed.
- IFG:
  - Load IDLE_BYTE; gcnt counts to IFG_LEN, then go to IDLE.
  - A new frame can start no earlier than the boundary after the last gap byte.
- Consecutive packets are always separated by exactly IFG_LEN gap bytes; back-to-back tvalid does not shorten the gap.
- Reset mid-frame: the frame is truncated immediately and output_d returns to the reset value the next cycle. No abort byte is sent.
- Simultaneous tlast and DISCARD entry cannot occur; underflow is judged only on tvalid at the PAYLOAD boundary.

Optional Feature:
- Macro: SSIO_SDR_TX_CRC_EN.
- Defined:
  - CRC-8 with polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR.
  - Computed over payload bytes only; CRC resets on entry to PREAMBLE.
  - After the tlast byte, state CRC loads the CRC byte at the next boundary, pulses frame_sent and goes to IFG.
  - No CRC byte is sent on an aborted frame.
- Undefined: no CRC logic or CRC state; PAYLOAD goes directly to IFG.

Test Plan:
- Reset, idle, OUT_WIDTH=4: after rst, output_d toggles 7,0,7,0...; busy=0; tready=0.
- Frame 01,02,03 (tlast on 03), no CRC: nibbles 5,5 x7, then 5,D,1,0,2,0,3,0, then 7,0 x12. frame_sent pulses once. busy falls after the 12th gap byte.
- Same frame with SSIO_SDR_TX_CRC_EN: after 3,0, nibbles 8,4 (CRC 0x48), then the gap.
- Underflow: tvalid dropped after byte 02. Output shows 2,0 then E,F (0xFE) and underflow pulses. Subsequent bytes through tlast are consumed with tready=1 and not transmitted. The gap follows; frame_sent stays 0.
- Back-to-back frames with tvalid held high: exactly 12 idle bytes between the last byte of frame 1 and the first 0x55 of frame 2.
- OUT_WIDTH=1 and OUT_WIDTH=8 with the same frame: bit order is LSB-first, and there is exactly one byte per 8 cycles and per 1 cycle respectively.
